// File: rtl/wb_host_sequencer.sv
// Wishbone classic initiator: turns valid/ready single or incrementing-burst commands
// into bus cycles and returns one response per beat, aborting a beat on ack timeout.
module wb_host_sequencer #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             rsp_valid,
    output logic [31:0]      rsp_dat,
    output logic             rsp_last,
    output logic             rsp_timeout,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, beat_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             we_reg;
    logic [3:0]       sel_reg;
    logic [31:0]      adr_reg, dat_reg;
    logic             rsp_valid_reg, rsp_last_reg, rsp_timeout_reg;
    logic [31:0]      rsp_dat_reg;

    logic accept, beat_last, beat_expire;

    assign accept      = cmd_valid && cmd_ready;
    assign beat_last   = (beat_reg == len_reg);
    // Ack on the expiry edge wins, so expiry is only taken when ack is low.
    assign beat_expire = TO_EN && (state_reg == REQ) && !wbm_ack_i && (to_cnt_reg == TO_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (wbm_ack_i) begin
                    state_next = beat_last ? IDLE : GAP;
                end else if (beat_expire) begin
                    state_next = IDLE;
                end
            end
            GAP:     state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // cyc/stb decode straight from the state register, so a reset edge drops them at once.
    always_comb begin
        cmd_ready = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE: cmd_ready = !wb_rst_i;
            REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                busy      = 1'b1;
            end
            GAP: begin
                wbm_cyc_o = 1'b1;
                busy      = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            len_reg         <= '0;
            beat_reg        <= '0;
            to_cnt_reg      <= '0;
            we_reg          <= 1'b0;
            sel_reg         <= '0;
            adr_reg         <= '0;
            dat_reg         <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_dat_reg     <= '0;
            rsp_last_reg    <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (accept) begin
                we_reg     <= cmd_we;
                adr_reg    <= cmd_adr;
                dat_reg    <= cmd_dat;
                sel_reg    <= cmd_sel;
                len_reg    <= cmd_len;
                beat_reg   <= '0;
                to_cnt_reg <= '0;
            end
            if (state_reg == GAP) begin
                to_cnt_reg <= '0;
            end
            if (state_reg == REQ) begin
                if (wbm_ack_i) begin
                    rsp_valid_reg   <= 1'b1;
                    rsp_dat_reg     <= we_reg ? 32'h0 : wbm_dat_i;
                    rsp_last_reg    <= beat_last;
                    rsp_timeout_reg <= 1'b0;
                    if (!beat_last) begin
                        // Plain 32-bit add: wraps modulo 2^32 and keeps adr[1:0].
                        adr_reg  <= adr_reg + 32'd4;
                        beat_reg <= beat_reg + 1'b1;
                    end
                end else if (beat_expire) begin
                    rsp_valid_reg   <= 1'b1;
                    rsp_dat_reg     <= 32'h0;
                    rsp_last_reg    <= 1'b1;
                    rsp_timeout_reg <= 1'b1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign wbm_we_o    = we_reg;
    assign wbm_sel_o   = sel_reg;
    assign wbm_adr_o   = adr_reg;
    assign wbm_dat_o   = dat_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_dat     = rsp_dat_reg;
    assign rsp_last    = rsp_last_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_wb_host_sequencer.sv
// Directed bench for wb_host_sequencer: scripted slave, beat/response scoreboards
// and bus-protocol checks at the falling edge.
module tb_wb_host_sequencer;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_adr;
    logic [31:0]      cmd_dat;
    logic [3:0]       cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic             wbm_ack_i;
    logic             rsp_valid, rsp_last, rsp_timeout, busy;
    logic [31:0]      rsp_dat;

    wb_host_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .cmd_len     (cmd_len),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .rsp_valid   (rsp_valid),
        .rsp_dat     (rsp_dat),
        .rsp_last    (rsp_last),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic        to;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    rsp_t        rsp_q[$];
    beat_t       beat_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          ack_delay = 0;
    logic        force_ack = 1'b0;
    logic [31:0] rd_xor = 32'h1234_5678;
    int          slv_wait = 0;
    int          stb_run = 0;
    int          last_run = 0;
    int          gap_cnt = 0;
    logic        prev_stb = 1'b0;

    function automatic void chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: acks the beat on its (ack_delay+1)-th strobe cycle; read data = adr ^ rd_xor.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (wbm_cyc_o && wbm_stb_o) begin
                wbm_ack_i = (slv_wait == ack_delay);
                wbm_dat_i = wbm_ack_i ? (wbm_adr_o ^ rd_xor) : 32'hDEAD_BEEF;
                slv_wait++;
            end else begin
                wbm_ack_i = force_ack;
                wbm_dat_i = 32'hDEAD_BEEF;
                slv_wait  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (wbm_stb_o) begin
            chk("stb_without_cyc", wbm_cyc_o, 1'b1);
            if (!prev_stb && gap_cnt > 0) chk("gap_len", gap_cnt, 1);
            stb_run++;
            gap_cnt = 0;
        end else begin
            if (prev_stb) last_run = stb_run;
            stb_run = 0;
            gap_cnt = wbm_cyc_o ? gap_cnt + 1 : 0;
        end
        prev_stb = wbm_stb_o;
        if (wbm_stb_o && wbm_ack_i) begin
            chk("beat_expected", beat_q.size() != 0, 1'b1);
            if (beat_q.size() != 0) begin
                beat_t eb;
                eb = beat_q.pop_front();
                chk("beat_we_sel_adr_dat", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, eb);
            end
        end
        if (rsp_valid) begin
            chk("rsp_expected", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
                rsp_t er;
                er = rsp_q.pop_front();
                chk("rsp_dat_last_to", {rsp_dat, rsp_last, rsp_timeout}, er);
            end
            if (rsp_last) chk("after_last_cyc_ready", {wbm_cyc_o, cmd_ready}, 2'b01);
        end
    end

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int len, input int n_ok, input bit to_end);
        logic [31:0] a;
        int k;
        for (int i = 0; i < n_ok; i++) begin
            a = adr + 32'(4 * i);
            beat_q.push_back(beat_t'({we, sel, a, dat}));
            rsp_q.push_back(rsp_t'({(we ? 32'h0 : (a ^ rd_xor)), (i == len), 1'b0}));
        end
        if (to_end) rsp_q.push_back(rsp_t'({32'h0, 1'b1, 1'b1}));
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_to_stb", {wbm_cyc_o, wbm_stb_o}, 2'b11);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || rsp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy_pending", {busy, rsp_q.size() != 0, beat_q.size() != 0}, 3'b000);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        cmd_len   = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
            rsp_valid, rsp_dat, rsp_last, rsp_timeout, busy, cmd_ready}, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {wbm_cyc_o, wbm_stb_o, busy, rsp_valid, cmd_ready}, 5'b00001);

        // Single write, ack on the third strobe cycle
        ack_delay = 2;
        send(1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'hF, 0, 1, 1'b0);
        wait_idle();
        chk("wr_stb_cycles", last_run, 3);

        // Single read returning 0x2A
        ack_delay = 0;
        rd_xor = 32'h3000_002E;
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 1, 1'b0);
        wait_idle();

        // 4-beat read burst
        ack_delay = 1;
        rd_xor = 32'h1234_5678;
        send(1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 4, 1'b0);
        wait_idle();

        // Slave never acks: single timeout response after TIMEOUT strobe cycles
        ack_delay = 1000;
        send(1'b0, 32'h0000_0200, 32'h0, 4'hF, 2, 0, 1'b1);
        wait_idle();
        chk("timeout_stb_cycles", last_run, TIMEOUT);

        // Address wrap, ack on the last allowed cycle
        ack_delay = TIMEOUT - 1;
        send(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h3, 1, 2, 1'b0);
        wait_idle();
        chk("tie_stb_cycles", last_run, TIMEOUT);

        // Unaligned write burst followed back-to-back by a read
        ack_delay = 0;
        send(1'b1, 32'h0000_0202, 32'h5EED_0F0F, 4'b0110, 2, 3, 1'b0);
        send(1'b0, 32'h0000_0400, 32'h0, 4'hC, 0, 1, 1'b0);
        wait_idle();

        // Reset after the third beat of a six-beat write
        send(1'b1, 32'h0000_0500, 32'hCAFE_0005, 4'hF, 5, 3, 1'b0);
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("pre_reset_rsp_count", n, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midburst_reset_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
            rsp_valid, rsp_dat, rsp_last, rsp_timeout, busy, cmd_ready}, 128'h0);
        force_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_ack_ignored", {rsp_valid, busy, wbm_cyc_o, cmd_ready}, 4'b0001);
        end
        force_ack = 1'b0;
        @(negedge clk);
        chk("reset_dropped_beats", {rsp_q.size() != 0, beat_q.size() != 0}, 2'b00);

        // Fresh command after reset
        ack_delay = 1;
        send(1'b0, 32'h0000_0600, 32'h0, 4'hF, 1, 2, 1'b0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_host_sequencer.md
Name: wb_host_sequencer

Overview:
- Wishbone classic initiator (master), the requesting end of the WB MI A slave bus used by the user project.
- Accepts single or incrementing-burst read/write commands on a valid/ready command port and performs the bus cycles.
- Returns one response per beat, with a per-beat ack timeout.
- Used to drive on-chip Wishbone slaves, such as the counter, from LA probes or a local controller.

Parameters:
- LEN_W, 8, width of cmd_len; a burst is cmd_len+1 beats (max 2^LEN_W).
- TIMEOUT, 64, cycles a beat may wait for ack before abort; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- wb_clk_i  in  1  single clock, all logic on posedge.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  start byte address.
- cmd_dat  in  32  write data, same word for every beat (fill).
- cmd_sel  in  4  byte selects, all beats.
- cmd_len  in  LEN_W  beats minus one.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave ack.
- rsp_valid  out  1  one-cycle pulse per completed or aborted beat.
- rsp_dat  out  32  read data; 0 for writes and timeouts.
- rsp_last  out  1  final response of the command.
- rsp_timeout  out  1  beat aborted by timeout.
- busy  out  1  command in progress (state != IDLE).

Behaviour:
- Reset: every output register is 0 (cyc, stb, we, sel, adr, dat_o, rsp_*, busy); state IDLE. cmd_ready is 1 in IDLE once reset is deasserted.
- Reset asserted mid-burst: cyc/stb drop at that same edge and the command is discarded with no response. Acks arriving after reset are ignored.
- States: IDLE, REQ, GAP.
- IDLE: cmd_ready=1. On valid&ready:
  - latch we/adr/dat/sel/len.
  - next cycle cyc=1, stb=1, beat counter=0, timeout counter=0 -> REQ.
  - Accept-to-strobe latency is 1 cycle.
- REQ: stb=1; the timeout counter increments each cycle. At an edge with ack=1:
  - rsp_valid=1 next cycle; rsp_dat=wbm_dat_i if read, else 0.
  - stb=0.
  - If beat==len: rsp_last=1, cyc=0 -> IDLE.
  - Otherwise: adr+=4, beat+=1 -> GAP.
- GAP: exactly one cycle with cyc=1, stb=0; then stb=1, timeout counter cleared -> REQ.
- Timeout: TIMEOUT!=0 and the counter reaches TIMEOUT-1 in REQ without ack:
  - next cycle cyc=0, stb=0.
  - rsp_valid=1, rsp_timeout=1, rsp_last=1, rsp_dat=0.
  - -> IDLE; remaining beats are dropped.
  - Ack on the same edge as expiry: ack wins (normal beat).
- ack while stb=0 (GAP/IDLE): ignored.
- rsp_* are valid for one cycle only; there is no backpressure. rsp_* other than rsp_valid hold their last value otherwise.
- Address increment is modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000); adr[1:0] is preserved.
- we/sel/dat_o are stable for the entire cycle (cyc high).
- Back-to-back commands: the last response and the next acceptance may coincide (IDLE cycle). Minimum 1 idle cycle between bursts.
- Maximum burst length 2^LEN_W beats; beat counter width LEN_W.

Test Plan:
- Single write: adr=0x30000000, dat=0xA5A5_0001, sel=0xF, len=0, ack after 2 cycles -> one stb pulse with we=1, dat_o=0xA5A50001; rsp_valid=1, rsp_last=1, rsp_dat=0; cyc low the next cycle.
- Single read: len=0, slave returns 0x0000_002A with ack -> rsp_dat=0x2A, rsp_last=1, rsp_timeout=0.
- 4-beat read burst: adr=0x100, len=3, ack after 1 cycle -> adr sequence 0x100, 0x104, 0x108, 0x10C; cyc high throughout; stb low exactly 1 cycle between beats; 4 rsp pulses, rsp_last on the 4th only.
- Timeout: TIMEOUT=8, len=2, slave never acks -> stb high 8 cycles, then cyc=0; single rsp with rsp_timeout=1, rsp_last=1; cmd_ready=1 next cycle.
- Reset mid-burst: len=5, assert wb_rst_i after beat 2 -> next edge all outputs 0, no further rsp; a new command after reset completes normally.
- Address wrap and ack/timeout tie: adr=0xFFFFFFFC, len=1 -> second beat at 0x00000000. Ack on the TIMEOUT-1 cycle -> normal response, rsp_timeout=0.
